// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-index width,
// operand-forwarding select encodings and the hazard scoreboard entry.
package mips_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } sb_entry_t;

    // A slot only matters if it will really write a register other than $0.
    function automatic logic is_producer(input sb_entry_t e);
        return e.valid & e.regwrite & (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational forward-select for one EX operand: picks EX/MEM, MEM/WB or the
// register file based on the EX and MEM scoreboard slots.
module fwd_select (
    input  logic [mips_pkg::REG_W-1:0] src,
    input  logic                       uses,
    input  mips_pkg::sb_entry_t        ex_slot,
    input  mips_pkg::sb_entry_t        mem_slot,
    output logic [1:0]                 sel
);
    import mips_pkg::*;

    // The EX slot is the younger producer and so takes priority; a load in EX
    // has no result yet and is handled by the load-use stall instead.
    always_comb begin
        sel = FWD_REG;
        if (uses) begin
            if (is_producer(ex_slot) && !ex_slot.memread && (ex_slot.rd == src)) begin
                sel = FWD_EXMEM;
            end else if (is_producer(mem_slot) && (mem_slot.rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall and ALU operand-forwarding control for the 5-stage MIPS core.
// Optional stall counter is built when HAZARD_PERF_CNT_EN is defined.
module hazard_forward_unit #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush_id,
    output logic              stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [DATA_W-1:0] stall_count,
`endif
    output logic              ex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);
    import mips_pkg::*;

    sb_entry_t  ex_q,  ex_d;
    sb_entry_t  mem_q, mem_d;
    sb_entry_t  wb_q,  wb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       ex_bubble_q, ex_bubble_d;
    logic [1:0] sel_a, sel_b;
    logic       load_use;
    logic       issue;

    fwd_select u_fwd_a (
        .src      (id_rs),
        .uses     (id_uses_rs),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (sel_a)
    );

    fwd_select u_fwd_b (
        .src      (id_rt),
        .uses     (id_uses_rt),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (sel_b)
    );

    always_comb begin
        load_use = is_producer(ex_q) & ex_q.memread &
                   ((id_uses_rs & (ex_q.rd == id_rs)) |
                    (id_uses_rt & (ex_q.rd == id_rt)));
        // A squashed instruction never stalls, so flush wins over the hazard.
        stall    = id_valid & ~flush_id & load_use;
        issue    = id_valid & ~flush_id & ~stall;
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        ex_bubble_d = ex_bubble_q;
        if (!hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (issue) begin
                ex_d.valid    = 1'b1;
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                fwd_a_d       = sel_a;
                fwd_b_d       = sel_b;
            end else begin
                ex_d    = '0;
                fwd_a_d = FWD_REG;
                fwd_b_d = FWD_REG;
            end
            ex_bubble_d = ~issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            ex_bubble_q <= 1'b1;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign ex_bubble = ex_bubble_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [DATA_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (!hold && stall) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit (stall counter checks
// compile in when HAZARD_PERF_CNT_EN is defined).
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt;
    logic       id_regwrite, id_memread;
    logic       flush_id;
    logic       stall;
    logic       ex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] cnt_snap;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush_id    (flush_id),
        .stall       (stall),
`ifdef HAZARD_PERF_CNT_EN
        .stall_count (stall_count),
`endif
        .ex_bubble   (ex_bubble),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush_id = 1'b0;
        nop();
        #12;
        chk("reset_fwd_a", fwd_a_sel, 2'b00);
        chk("reset_fwd_b", fwd_b_sel, 2'b00);
        chk("reset_bubble", ex_bubble, 1'b1);
        chk("reset_stall", stall, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk("reset_count", stall_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_bubble", ex_bubble, 1'b1);
        chk("idle_fwd_a", fwd_a_sel, 2'b00);
        chk("idle_stall", stall, 1'b0);

        // add $3 ; sub $4,$3,$5 -> EX/MEM forward
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        chk("add3_issued", ex_bubble, 1'b0);
        drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
        chk("sub_nostall", stall, 1'b0);
        tick();
        chk("back2back_fwd_a", fwd_a_sel, 2'b10);
        chk("back2back_fwd_b", fwd_b_sel, 2'b00);

        // add $7 ; nop ; use $7 -> MEM/WB forward
        drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
        tick();
        nop();
        tick();
        chk("nop_bubble", ex_bubble, 1'b1);
        drive(1, 5'd7, 5'd9, 1, 1, 5'd14, 1, 0);
        tick();
        chk("gap1_fwd_a", fwd_a_sel, 2'b01);
        chk("gap1_fwd_b", fwd_b_sel, 2'b00);

        // add $8 ; nop ; nop ; use $8 -> register file
        drive(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0);
        tick();
        nop(); tick();
        nop(); tick();
        drive(1, 5'd8, 5'd8, 1, 1, 5'd15, 1, 0);
        tick();
        chk("gap2_fwd_a", fwd_a_sel, 2'b00);
        chk("gap2_fwd_b", fwd_b_sel, 2'b00);

        // two writers of $10: the younger one wins; older one seen on B via MEM
        drive(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0);
        tick();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd16, 1, 0);
        tick();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0);
        tick();
        drive(1, 5'd10, 5'd16, 1, 1, 5'd17, 1, 0);
        tick();
        chk("younger_fwd_a", fwd_a_sel, 2'b10);
        chk("older_fwd_b", fwd_b_sel, 2'b01);

        // lw $2 ; add $6,$2,$2 -> one stall cycle then MEM/WB forward
        drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
        tick();
        drive(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
        chk("loaduse_stall", stall, 1'b1);
        tick();
        chk("loaduse_bubble", ex_bubble, 1'b1);
        chk("loaduse_bubble_fwd_a", fwd_a_sel, 2'b00);
        chk("loaduse_stall_released", stall, 1'b0);
        tick();
        chk("loaduse_fwd_a", fwd_a_sel, 2'b01);
        chk("loaduse_fwd_b", fwd_b_sel, 2'b01);
        chk("loaduse_issued", ex_bubble, 1'b0);

        // producers of $0 (ALU then load) never forward or stall
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        tick();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd18, 1, 0);
        chk("zero_stall", stall, 1'b0);
        tick();
        chk("zero_fwd_a", fwd_a_sel, 2'b00);
        chk("zero_fwd_b", fwd_b_sel, 2'b00);

        // lw $2 then dependent add squashed by flush
        drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
        tick();
        flush_id = 1'b1;
        drive(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
        chk("flush_stall", stall, 1'b0);
        tick();
        flush_id = 1'b0;
        chk("flush_bubble", ex_bubble, 1'b1);
        chk("flush_fwd_a", fwd_a_sel, 2'b00);

        // add $11 ; lw $2,0($11) ; dependent add with a 3-cycle hold
        drive(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0);
        tick();
        drive(1, 5'd11, 5'd0, 1, 0, 5'd2, 1, 1);
        tick();
        chk("lw_fwd_a", fwd_a_sel, 2'b10);
        drive(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
        chk("pre_hold_stall", stall, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
        cnt_snap = stall_count;
`endif
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_bubble", ex_bubble, 1'b0);
            chk("hold_fwd_a", fwd_a_sel, 2'b10);
            chk("hold_stall", stall, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
            chk("hold_count", stall_count, cnt_snap);
`endif
        end
        hold = 1'b0;
        tick();
        chk("post_hold_bubble", ex_bubble, 1'b1);
        chk("post_hold_fwd_a", fwd_a_sel, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("post_hold_count", stall_count, cnt_snap + 32'd1);
`endif
        tick();
        chk("post_hold_fwd_a2", fwd_a_sel, 2'b01);
        chk("post_hold_fwd_b2", fwd_b_sel, 2'b01);

        // EX = lw $13, MEM = add $12, then asynchronous reset
        drive(1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 0);
        tick();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd13, 1, 1);
        tick();
        drive(1, 5'd13, 5'd12, 1, 1, 5'd19, 1, 0);
        chk("pre_reset_stall", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_bubble", ex_bubble, 1'b1);
        chk("async_reset_stall", stall, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("after_reset_fwd_a", fwd_a_sel, 2'b00);
        chk("after_reset_fwd_b", fwd_b_sel, 2'b00);
        chk("after_reset_issued", ex_bubble, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        chk("after_reset_count", stall_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
            tick();
            drive(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
            tick();
            tick();
        end
        chk("five_stalls_count", stall_count, 32'd5);
`endif

        nop();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
